// File: rtl/rl_pixel_decoder.sv
// rl_pixel_decoder: turns CD-i passthrough/RL7/RL3 bytes into one CLUT index per pixel,
// counting pixels per line, clipping runs at the line end and pulsing line completion.
module rl_pixel_decoder #(
    parameter int unit_index = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_mode,
    input  logic       i_line_start,
    input  logic [9:0] i_line_width,
    input  logic       i_in_write,
    input  logic [7:0] i_in_pixel,
    output logic       o_in_strobe,
    output logic       o_out_write,
    output logic [7:0] o_out_pixel,
    input  logic       i_out_strobe,
    output logic       o_line_done
);
    typedef enum logic [1:0] {S_DONE, S_FETCH, S_COUNT, S_RUN} state_t;

    state_t     r_state, w_state;
    logic [9:0] r_pixels_left, w_pixels_left;
    logic [9:0] r_run_left, w_run_left;
    logic [6:0] r_col_a, w_col_a;
    logic [2:0] r_col_b, w_col_b;
    logic       r_phase, w_phase;
    logic [1:0] r_mode, w_mode;
    logic       r_line_done, w_line_done;
    logic       w_pass, w_rl7;

    assign w_pass      = (r_mode == 2'd0) || (r_mode == 2'd3);
    assign w_rl7       = r_mode == 2'd1;
    assign o_line_done = r_line_done;
    // Passthrough is a combinational wire from upstream to downstream while fetching.
    assign o_in_strobe = (r_state == S_COUNT) || (r_state == S_FETCH && (!w_pass || i_out_strobe));
    assign o_out_write = (r_state == S_RUN) || (r_state == S_FETCH && w_pass && i_in_write);
    assign o_out_pixel = (r_state == S_FETCH && w_pass) ? i_in_pixel :
                         (r_state != S_RUN) ? 8'd0 :
                         w_rl7 ? {1'b0, r_col_a} : {5'd0, r_phase ? r_col_b : r_col_a[2:0]};

    always_comb begin
        w_state       = r_state;
        w_pixels_left = r_pixels_left;
        w_run_left    = r_run_left;
        w_col_a       = r_col_a;
        w_col_b       = r_col_b;
        w_phase       = r_phase;
        w_mode        = r_mode;
        w_line_done   = 1'b0;
        if (i_line_start) begin
            w_pixels_left = i_line_width;
            w_mode        = i_mode;
            w_phase       = 1'b0;
            w_state       = (i_line_width == 10'd0) ? S_DONE : S_FETCH;
            w_line_done   = i_line_width == 10'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_pass) begin
                        if (i_in_write && i_out_strobe) begin
                            w_pixels_left = r_pixels_left - 10'd1;
                            w_state       = (r_pixels_left == 10'd1) ? S_DONE : S_FETCH;
                            w_line_done   = r_pixels_left == 10'd1;
                        end
                    end else if (i_in_write) begin
                        w_col_a    = w_rl7 ? i_in_pixel[6:0] : {4'd0, i_in_pixel[6:4]};
                        w_col_b    = w_rl7 ? r_col_b : i_in_pixel[2:0];
                        w_run_left = w_rl7 ? 10'd1 : 10'd2;
                        w_state    = i_in_pixel[7] ? S_COUNT : S_RUN;
                    end
                end
                S_COUNT: begin
                    if (i_in_write) begin
                        // A zero count means "run to the end of the line".
                        w_run_left = (i_in_pixel == 8'd0) ? r_pixels_left :
                                     w_rl7 ? {2'd0, i_in_pixel} : {1'b0, i_in_pixel, 1'b0};
                        w_state    = S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_out_strobe) begin
                        w_pixels_left = r_pixels_left - 10'd1;
                        w_run_left    = r_run_left - 10'd1;
                        w_phase       = w_rl7 ? r_phase : ~r_phase;
                        w_state       = (r_pixels_left == 10'd1) ? S_DONE :
                                        (r_run_left == 10'd1) ? S_FETCH : S_RUN;
                        w_line_done   = r_pixels_left == 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_DONE;
            r_pixels_left <= 10'd0;
            r_run_left    <= 10'd0;
            r_col_a       <= 7'd0;
            r_col_b       <= 3'd0;
            r_phase       <= 1'b0;
            r_mode        <= 2'd0;
            r_line_done   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pixels_left <= w_pixels_left;
            r_run_left    <= w_run_left;
            r_col_a       <= w_col_a;
            r_col_b       <= w_col_b;
            r_phase       <= w_phase;
            r_mode        <= w_mode;
            r_line_done   <= w_line_done;
        end
    end
endmodule

// File: doc/rl_pixel_decoder.md
# rl_pixel_decoder

Downstream consumer of the display file FIFO's byte-wide `pixelstream`. It decodes the CD-i coding selected for a plane into a stream of 8-bit CLUT indices, one per pixel, for the pixel pipeline.
- Supported codings: CLUT passthrough, RL7 and RL3.
- It counts pixels per display line, clips runs at the line end and signals line completion.
- One instance sits behind each file decoder unit.

## Interface
Parameters:
- `unit_index`, default 0: plane number, used only in simulation messages.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `mode` in 2: coding, latched at `line_start`. 0 = passthrough, 1 = RL7, 2 = RL3, 3 = passthrough.
- `line_start` in 1: one-cycle pulse that starts a new line.
- `line_width` in 10: output pixels per line, latched at `line_start`.
- `in` pixelstream.sink: bytes from the display file FIFO.
  - `in.write`: byte valid.
  - `in.pixel[7:0]`: the byte.
  - `in.strobe`: driven here; consumes the byte.
- `out` pixelstream.source: decoded CLUT indices.
  - `out.write`: pixel valid.
  - `out.pixel[7:0]`: the index.
  - `out.strobe`: from the sink; consumes the pixel.
- `line_done` out 1: one-cycle pulse when the line's last pixel is consumed.

## Operation
- **Transfers.** A transfer on either stream occurs in a cycle where `write && strobe` are both high. Upstream data may change only in the cycle after a transfer.
- **Registers.**
  - `pixels_left[9:0]`: pixels remaining in the line.
  - `run_left[9:0]`: pixels remaining in the current run.
  - `col_a[6:0]`, `col_b[2:0]`: run colours.
  - `phase`: RL3 alternation bit.
  - Latched `mode_q`.
- **States.** DONE, FETCH, COUNT, RUN. DONE is the reset and idle state.
- **DONE.**
  - `in.strobe` = 0 and `out.write` = 0.
  - Upstream bytes are left untouched.
- **`line_start` (any state, highest priority).**
  - `pixels_left` ← `line_width`, `mode_q` ← `mode`, `phase` ← 0.
  - Next state is FETCH, or DONE if `line_width` = 0. Entering DONE this way pulses `line_done` in the next cycle.
  - Any `out.strobe` in the same cycle is ignored.
- **Passthrough (FETCH only, no RUN).**
  - `out.pixel` = `in.pixel` and `out.write` = `in.write`.
  - `in.strobe` = `out.strobe`, combinationally.
  - Each transfer decrements `pixels_left`. The transfer that takes it from 1 to 0 moves the block to DONE.
- **FETCH (RL modes).**
  - `in.strobe` = 1.
  - On a transfer of byte b:
    - b[7] = 0: set `run_left` to 1 for RL7 or 2 for RL3, then go to RUN.
    - b[7] = 1: go to COUNT.
  - RL7 colour: `col_a` ← b[6:0].
  - RL3 colours: `col_a` ← b[6:4], `col_b` ← b[2:0].
- **COUNT.**
  - `in.strobe` = 1.
  - On a transfer of byte n, `run_left` is set as follows, then go to RUN:
    - n = 0: `pixels_left` (run to end of line).
    - RL7: n.
    - RL3: 2·n.
- **RUN.**
  - `out.write` = 1 and `in.strobe` = 0.
  - `out.pixel` for RL7 is {0, `col_a`}.
  - `out.pixel` for RL3 is {00000, `col_a`} when `phase` = 0 and {00000, `col_b`} when `phase` = 1.
  - On `out.strobe`: decrement `run_left` and `pixels_left`, and toggle `phase` (RL3 only).
  - If `pixels_left` reaches 0: go to DONE and pulse `line_done`. Any residual run is discarded, which is the clipping rule.
  - Else if `run_left` reaches 0: go to FETCH. `phase` carries over so pairs stay aligned.
- **Width rule.** Run arithmetic is 10-bit. The RL3 value 2·n is at most 510.

## Timing
- **Reset values.**
  - Outputs: `out.write` = 0, `in.strobe` = 0, `line_done` = 0, `out.pixel` = 0.
  - State: DONE, all counters 0.
- **Reset mid-line.** The next cycle is DONE with no `line_done` pulse.
- **RL single-pixel command.**
  - Byte transferred in cycle N; `out.write` is high in cycle N+1.
  - The next FETCH is no earlier than the cycle after the last pixel transfer.
- **RL run command.**
  - Command byte in N; count byte transferred no earlier than N+1; `out.write` no earlier than N+2.
- **Passthrough.** Zero latency, with a combinational path from `in` to `out`.
- **Throughput.** In RUN, one pixel per cycle while `out.strobe` is held high.
- **`line_done` timing.**
  - It is high exactly in the cycle after the final pixel transfer.
  - It is not asserted again until the next `line_start`.
- **`line_start` during RUN.** Drops `out.write` in the next cycle. The partially emitted run is abandoned.

## Test plan
1. **RL7 run.** RL7, width 8, bytes 0x85, 0x03, 0x12 → pixels 05, 05, 05, 12 with `in.strobe` idle afterward. Then continue with 0x81, 0x00 → 81 00 gives four 01 pixels, `line_done` pulses, `out.write` = 0.
2. **RL7 clipping.** RL7, width 4, bytes 0x9F, 0x0A → exactly four 1F pixels, then `line_done`. The next byte is not consumed.
3. **RL3 pairs.** RL3, width 6, bytes 0xD2, 0x02, 0x31 → pixels 05, 02, 05, 02, 03, 01, then `line_done`.
4. **Passthrough with back-pressure.** Mode 0, width 3, bytes A0, B1, C2 with `out.strobe` toggled 1, 0, 1, 1 → `out.pixel` tracks `in.pixel`, each byte is consumed only on `out.strobe`, and `line_done` comes after C2.
5. **Line restart and zero width.** `line_start` during RUN with `out.strobe` high → no pixel counted, FETCH next, counters reloaded. Width 0 → DONE and a single `line_done` pulse.
6. **Reset mid-run.** `reset` asserted in RUN → next cycle `out.write` = 0, `in.strobe` = 0, no `line_done`. After the next `line_start`, decoding starts cleanly from a fresh command byte.
